// File: rtl/line_refill_ctrl.sv
// Cache line refill controller: optional dirty-victim writeback followed by a
// line read from off-chip memory. Each memory phase waits for a ready
// handshake and is bounded by a timeout.
module line_refill_ctrl #(
  parameter int LINE_BYTES = 32,
  parameter int ADDR_W     = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req,
  input  logic [ADDR_W-1:0]       miss_addr,
  input  logic                    evict_dirty,
  input  logic [ADDR_W-1:0]       evict_addr,
  input  logic [LINE_BYTES*8-1:0] evict_data,
  output logic                    busy,
  output logic [LINE_BYTES*8-1:0] refill_data,
  output logic                    refill_valid,
  output logic                    refill_err,
  output logic [ADDR_W-1:0]       offchip_mem_addr,
  output logic [LINE_BYTES*8-1:0] offchip_mem_wdata,
  output logic                    offchip_mem_write_en,
  output logic                    offchip_mem_read_en,
  input  logic [LINE_BYTES*8-1:0] offchip_mem_data,
  input  logic                    offchip_mem_ready
);

  localparam int LINE_W = LINE_BYTES * 8;
  localparam int CNT_W  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WB   = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_RD   = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Clears the byte-offset bits so every memory address is line aligned.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_BYTES - 1);

  logic [2:0]        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [ADDR_W-1:0] miss_addr_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic [LINE_W-1:0] refill_data_reg;
  logic              err_reg;
  logic              in_phase;
  logic              timeout_hit;

  // A phase is a WB or RD wait; the last allowed wait cycle is TIMEOUT-1.
  assign in_phase    = (state_reg == ST_WB) || (state_reg == ST_RD);
  assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT - 1));

  // Enables and status decode straight from the registered state, so the two
  // enables are mutually exclusive by construction.
  assign busy                 = (state_reg != ST_IDLE);
  assign offchip_mem_write_en = (state_reg == ST_WB);
  assign offchip_mem_read_en  = (state_reg == ST_RD);
  assign refill_valid         = (state_reg == ST_DONE);
  assign refill_err           = err_reg;
  assign refill_data          = refill_data_reg;
  assign offchip_mem_addr     = addr_reg;
  assign offchip_mem_wdata    = wdata_reg;

  // Next-state selection; ready only matters while a phase is waiting.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (miss_req) begin
          state_next = evict_dirty ? ST_WB : ST_RD;
        end
      end
      ST_WB: begin
        if (offchip_mem_ready) begin
          state_next = ST_GAP;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_GAP:  state_next = ST_RD;
      ST_RD: begin
        if (offchip_mem_ready) begin
          state_next = ST_DONE;
        end else if (timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register and per-phase wait counter (cleared on every state change).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next != state_reg) begin
        cnt_reg <= '0;
      end else if (in_phase) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  // Request capture, address sequencing, returned line and error pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      miss_addr_reg   <= '0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      refill_data_reg <= '0;
      err_reg         <= 1'b0;
    end else begin
      err_reg <= in_phase && !offchip_mem_ready && timeout_hit;
      if (state_reg == ST_IDLE && miss_req) begin
        miss_addr_reg <= miss_addr & ALIGN_MASK;
        wdata_reg     <= evict_data;
        addr_reg      <= evict_dirty ? (evict_addr & ALIGN_MASK)
                                     : (miss_addr & ALIGN_MASK);
      end
      if (state_reg == ST_WB && offchip_mem_ready) begin
        addr_reg <= miss_addr_reg;
      end
      if (state_reg == ST_RD && offchip_mem_ready) begin
        refill_data_reg <= offchip_mem_data;
      end
    end
  end

endmodule

// File: tb/tb_line_refill_ctrl.sv
// Testbench for line_refill_ctrl: a latency-programmable memory responder,
// a scoreboard of expected memory requests and refill lines, and a protocol
// monitor running through every scenario.
module tb_line_refill_ctrl;

  localparam int LB = 32;
  localparam int AW = 32;
  localparam int TO = 8;
  localparam int LW = LB * 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          miss_req = 1'b0;
  logic [AW-1:0] miss_addr = '0;
  logic          evict_dirty = 1'b0;
  logic [AW-1:0] evict_addr = '0;
  logic [LW-1:0] evict_data = '0;
  logic          busy;
  logic [LW-1:0] refill_data;
  logic          refill_valid;
  logic          refill_err;
  logic [AW-1:0] offchip_mem_addr;
  logic [LW-1:0] offchip_mem_wdata;
  logic          offchip_mem_write_en;
  logic          offchip_mem_read_en;
  logic [LW-1:0] offchip_mem_data;
  logic          offchip_mem_ready = 1'b0;

  int checks_total  = 0;
  int checks_passed = 0;

  // scoreboard queues
  logic [AW-1:0] exp_rd_addr_q[$];
  logic [AW-1:0] exp_wr_addr_q[$];
  logic [LW-1:0] exp_wr_data_q[$];
  logic [LW-1:0] exp_line_q[$];

  // monitor statistics
  int valid_cnt = 0, err_cnt = 0, gap_cnt = 0, rd_cycles = 0, wr_cycles = 0;
  int ready_lat = -1;
  int resp_cnt  = 0;

  always #5 clk = ~clk;

  line_refill_ctrl #(.LINE_BYTES(LB), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr),
    .evict_dirty(evict_dirty), .evict_addr(evict_addr), .evict_data(evict_data),
    .busy(busy), .refill_data(refill_data), .refill_valid(refill_valid),
    .refill_err(refill_err),
    .offchip_mem_addr(offchip_mem_addr), .offchip_mem_wdata(offchip_mem_wdata),
    .offchip_mem_write_en(offchip_mem_write_en), .offchip_mem_read_en(offchip_mem_read_en),
    .offchip_mem_data(offchip_mem_data), .offchip_mem_ready(offchip_mem_ready)
  );

  function automatic logic [LW-1:0] line_for(input logic [AW-1:0] a);
    return {a, ~a, a ^ 32'h5A5A_A5A5, a + 32'h1111_1111, ~a + 32'd1,
            a ^ 32'hFFFF_0000, {a[15:0], a[31:16]}, a ^ 32'h1234_5678};
  endfunction

  // memory returns an address-dependent line only while a read is requested
  assign offchip_mem_data = offchip_mem_read_en ? line_for(offchip_mem_addr)
                                                : {8{32'hDEAD_BEEF}};

  // responder: ready goes high ready_lat cycles into a request (never if < 0)
  always @(negedge clk) begin
    if (rst && (offchip_mem_read_en || offchip_mem_write_en)) begin
      offchip_mem_ready = (ready_lat >= 0 && resp_cnt == ready_lat);
      resp_cnt = resp_cnt + 1;
    end else begin
      offchip_mem_ready = 1'b0;
      resp_cnt = 0;
    end
  end

  // protocol monitor and scoreboard consumer
  logic          prev_rd = 1'b0, prev_wr = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [LW-1:0] prev_wdata = '0;
  logic [LW-1:0] last_line = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_rd = 1'b0; prev_wr = 1'b0; last_line = '0;
    end else begin
      if (offchip_mem_read_en || offchip_mem_write_en) begin
        checks_total++;
        if (offchip_mem_read_en && offchip_mem_write_en)
          $display("FAIL both_en: got rd=1 wr=1 required at most one");
        else checks_passed++;
      end
      if (offchip_mem_read_en) rd_cycles++;
      if (offchip_mem_write_en) wr_cycles++;
      if (busy && !offchip_mem_read_en && !offchip_mem_write_en && !refill_valid) gap_cnt++;
      if (refill_err) err_cnt++;
      // start of a read request: compare against expected address
      if (offchip_mem_read_en && !prev_rd) begin
        checks_total++;
        if (exp_rd_addr_q.size() == 0)
          $display("FAIL rd_unexpected: got addr %h required no read", offchip_mem_addr);
        else begin
          logic [AW-1:0] ea;
          ea = exp_rd_addr_q.pop_front();
          if (offchip_mem_addr !== ea)
            $display("FAIL rd_addr: got %h required %h", offchip_mem_addr, ea);
          else checks_passed++;
        end
      end
      if (offchip_mem_write_en && !prev_wr) begin
        checks_total++;
        if (exp_wr_addr_q.size() == 0)
          $display("FAIL wr_unexpected: got addr %h required no write", offchip_mem_addr);
        else begin
          logic [AW-1:0] ea;
          logic [LW-1:0] ed;
          ea = exp_wr_addr_q.pop_front();
          ed = exp_wr_data_q.pop_front();
          if (offchip_mem_addr !== ea || offchip_mem_wdata !== ed)
            $display("FAIL wr_req: got %h/%h required %h/%h", offchip_mem_addr, offchip_mem_wdata, ea, ed);
          else checks_passed++;
        end
      end
      // request operands must hold while an enable stays high
      if ((offchip_mem_read_en && prev_rd) || (offchip_mem_write_en && prev_wr)) begin
        checks_total++;
        if (offchip_mem_addr !== prev_addr || (offchip_mem_write_en && offchip_mem_wdata !== prev_wdata))
          $display("FAIL req_stable: got addr %h required %h", offchip_mem_addr, prev_addr);
        else checks_passed++;
      end
      if (refill_valid) begin
        valid_cnt++;
        checks_total++;
        if (exp_line_q.size() == 0)
          $display("FAIL valid_unexpected: got refill_valid=1 required 0");
        else begin
          logic [LW-1:0] el;
          el = exp_line_q.pop_front();
          if (refill_data !== el)
            $display("FAIL refill_data: got %h required %h", refill_data, el);
          else checks_passed++;
          last_line = el;
        end
      end else begin
        checks_total++;
        if (refill_data !== last_line)
          $display("FAIL refill_hold: got %h required %h", refill_data, last_line);
        else checks_passed++;
      end
      prev_rd = offchip_mem_read_en;
      prev_wr = offchip_mem_write_en;
      prev_addr = offchip_mem_addr;
      prev_wdata = offchip_mem_wdata;
    end
  end

  // wait on a DUT condition: 0 idle, 1 refill_valid, 2 write_en, 3 refill_err
  task automatic wait_for(input int sel, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0 && !busy) || (sel == 1 && refill_valid) ||
          (sel == 2 && offchip_mem_write_en) || (sel == 3 && refill_err)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    checks_total++;
    if ({busy, offchip_mem_read_en, offchip_mem_write_en, refill_valid, refill_err} !== 5'b0)
      $display("FAIL reset_ctrl: got %b required 00000",
               {busy, offchip_mem_read_en, offchip_mem_write_en, refill_valid, refill_err});
    else checks_passed++;
    checks_total++;
    if (refill_data !== '0 || offchip_mem_addr !== '0 || offchip_mem_wdata !== '0)
      $display("FAIL reset_data: got addr %h required 0", offchip_mem_addr);
    else checks_passed++;
    #2 rst = 1'b1;
    $display("reset: released");
  endtask

  task automatic test_clean_miss();
    int v0, r0, w0, g0;
    bit ok;
    v0 = valid_cnt; r0 = rd_cycles; w0 = wr_cycles; g0 = gap_cnt;
    ready_lat = 3;
    miss_addr = 32'h1000_0014; evict_dirty = 1'b0;
    exp_rd_addr_q.push_back(32'h1000_0000);
    exp_line_q.push_back(line_for(32'h1000_0000));
    miss_req = 1'b1;
    @(negedge clk);
    checks_total++;
    if (busy !== 1'b1) $display("FAIL first_accept: got busy=%b required 1", busy);
    else checks_passed++;
    miss_req = 1'b0;
    wait_for(1, 20, ok);
    checks_total++;
    if (!ok) $display("FAIL clean_valid: got no refill_valid required pulse");
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (busy !== 1'b0 || refill_valid !== 1'b0)
      $display("FAIL clean_end: got busy=%b valid=%b required 0 0", busy, refill_valid);
    else checks_passed++;
    checks_total++;
    if (valid_cnt - v0 != 1 || rd_cycles - r0 != 4 || wr_cycles - w0 != 0 || gap_cnt - g0 != 0)
      $display("FAIL clean_counts: got v%0d r%0d w%0d g%0d required v1 r4 w0 g0",
               valid_cnt - v0, rd_cycles - r0, wr_cycles - w0, gap_cnt - g0);
    else checks_passed++;
    $display("clean miss: addr 10000014 done");
  endtask

  task automatic test_dirty_miss();
    int v0, r0, w0, g0;
    bit ok;
    logic [LW-1:0] pat_a;
    pat_a = line_for(32'h0BAD_F00D);
    v0 = valid_cnt; r0 = rd_cycles; w0 = wr_cycles; g0 = gap_cnt;
    ready_lat = 2;
    miss_addr = 32'h3000_0000; evict_dirty = 1'b1;
    evict_addr = 32'h2000_0040; evict_data = pat_a;
    exp_wr_addr_q.push_back(32'h2000_0040);
    exp_wr_data_q.push_back(pat_a);
    exp_rd_addr_q.push_back(32'h3000_0000);
    exp_line_q.push_back(line_for(32'h3000_0000));
    miss_req = 1'b1;
    @(negedge clk);
    miss_req = 1'b0; evict_dirty = 1'b0; evict_data = '0;
    wait_for(1, 30, ok);
    checks_total++;
    if (!ok) $display("FAIL dirty_valid: got no refill_valid required pulse");
    else checks_passed++;
    wait_for(0, 5, ok);
    checks_total++;
    if (!ok || valid_cnt - v0 != 1 || wr_cycles - w0 != 3 || rd_cycles - r0 != 3 || gap_cnt - g0 != 1)
      $display("FAIL dirty_counts: got v%0d w%0d r%0d g%0d required v1 w3 r3 g1",
               valid_cnt - v0, wr_cycles - w0, rd_cycles - r0, gap_cnt - g0);
    else checks_passed++;
    $display("dirty miss: wb 20000040 then rd 30000000 done");
  endtask

  task automatic test_timeout();
    int v0, e0, r0;
    bit ok;
    v0 = valid_cnt; e0 = err_cnt; r0 = rd_cycles;
    ready_lat = -1;
    miss_addr = 32'h4000_001C; evict_dirty = 1'b0;
    exp_rd_addr_q.push_back(32'h4000_0000);
    miss_req = 1'b1;
    @(negedge clk);
    miss_req = 1'b0;
    wait_for(3, 30, ok);
    checks_total++;
    if (!ok) $display("FAIL timeout_err: got no refill_err required pulse");
    else checks_passed++;
    checks_total++;
    if (busy !== 1'b0 || offchip_mem_read_en !== 1'b0)
      $display("FAIL timeout_abort: got busy=%b rd=%b required 0 0", busy, offchip_mem_read_en);
    else checks_passed++;
    @(negedge clk); @(negedge clk);
    checks_total++;
    if (err_cnt - e0 != 1 || valid_cnt - v0 != 0 || rd_cycles - r0 != TO)
      $display("FAIL timeout_counts: got e%0d v%0d r%0d required e1 v0 r%0d",
               err_cnt - e0, valid_cnt - v0, rd_cycles - r0, TO);
    else checks_passed++;
    $display("timeout: rd 40000000 aborted");
  endtask

  task automatic test_back_to_back();
    int v0;
    bit ok;
    v0 = valid_cnt;
    ready_lat = 1;
    miss_addr = 32'h5000_0004; evict_dirty = 1'b0;
    exp_rd_addr_q.push_back(32'h5000_0000);
    exp_line_q.push_back(line_for(32'h5000_0000));
    miss_req = 1'b1;
    @(negedge clk);
    miss_addr = 32'h6000_0038;
    exp_rd_addr_q.push_back(32'h6000_0020);
    exp_line_q.push_back(line_for(32'h6000_0020));
    wait_for(1, 20, ok);
    checks_total++;
    if (!ok) $display("FAIL b2b_first: got no refill_valid required pulse");
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (busy !== 1'b0) $display("FAIL b2b_idle_gap: got busy=%b required 0", busy);
    else checks_passed++;
    @(negedge clk);
    checks_total++;
    if (busy !== 1'b1) $display("FAIL b2b_restart: got busy=%b required 1", busy);
    else checks_passed++;
    miss_req = 1'b0;
    wait_for(0, 20, ok);
    checks_total++;
    if (!ok || valid_cnt - v0 != 2)
      $display("FAIL b2b_count: got %0d refills required 2", valid_cnt - v0);
    else checks_passed++;
    $display("back-to-back: 50000000 then 60000020 done");
  endtask

  task automatic test_reset_mid_wb();
    int v0, e0;
    bit ok;
    ready_lat = -1;
    miss_addr = 32'h7000_0000; evict_dirty = 1'b1;
    evict_addr = 32'h2000_0080; evict_data = line_for(32'hCAFE_0001);
    exp_wr_addr_q.push_back(32'h2000_0080);
    exp_wr_data_q.push_back(line_for(32'hCAFE_0001));
    miss_req = 1'b1;
    wait_for(2, 5, ok);
    checks_total++;
    if (!ok) $display("FAIL mid_wb_start: got no write_en required 1");
    else checks_passed++;
    miss_req = 1'b0; evict_dirty = 1'b0;
    v0 = valid_cnt; e0 = err_cnt;
    #2 rst = 1'b0;
    #1;
    checks_total++;
    if (offchip_mem_write_en !== 1'b0 || busy !== 1'b0)
      $display("FAIL async_reset: got wr=%b busy=%b required 0 0", offchip_mem_write_en, busy);
    else checks_passed++;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (12) @(negedge clk);
    checks_total++;
    if (busy !== 1'b0 || valid_cnt != v0 || err_cnt != e0)
      $display("FAIL post_reset: got busy=%b v%0d e%0d required 0 v0 e0",
               busy, valid_cnt - v0, err_cnt - e0);
    else checks_passed++;
    $display("reset mid-wb: aborted");
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_timeout();
    test_back_to_back();
    test_reset_mid_wb();
    checks_total++;
    if (exp_rd_addr_q.size() + exp_wr_addr_q.size() + exp_line_q.size() != 0)
      $display("FAIL scoreboard_drain: got %0d pending required 0",
               exp_rd_addr_q.size() + exp_wr_addr_q.size() + exp_line_q.size());
    else checks_passed++;
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/line_refill_ctrl.md
LINE_REFILL_CTRL -- requirements
Module: line_refill_ctrl

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 32, cache line size in bytes; power of two, at least 4.
REQ-002 SHALL have parameter ADDR_W, default 32, byte address width.
REQ-003 SHALL have parameter TIMEOUT, default 1023, maximum cycles to wait for offchip_mem_ready per phase; at least 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous and active-low.
REQ-006 SHALL have port miss_req, input, 1, level request from the cache for a line transaction.
REQ-007 SHALL have port miss_addr, input, ADDR_W, byte address of the missing line.
REQ-008 SHALL have port evict_dirty, input, 1, a dirty victim must be written back before the refill.
REQ-009 SHALL have port evict_addr, input, ADDR_W, byte address of the victim line.
REQ-010 SHALL have port evict_data, input, LINE_BYTES*8, victim line data.
REQ-011 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.
REQ-012 SHALL have port refill_data, output, LINE_BYTES*8, the returned line.
REQ-013 SHALL have port refill_valid, output, 1, one-cycle pulse when refill_data is valid.
REQ-014 SHALL have port refill_err, output, 1, one-cycle pulse on timeout abort.
REQ-015 SHALL have port offchip_mem_addr, output, ADDR_W, line-aligned address to memory.
REQ-016 SHALL have port offchip_mem_wdata, output, LINE_BYTES*8, writeback line.
REQ-017 SHALL have port offchip_mem_write_en, output, 1, level write request.
REQ-018 SHALL have port offchip_mem_read_en, output, 1, level read request.
REQ-019 SHALL have port offchip_mem_data, input, LINE_BYTES*8, read line from memory.
REQ-020 SHALL have port offchip_mem_ready, input, 1, memory completion for the current request.

Function
REQ-021 SHALL implement FSM states IDLE, WB, GAP, RD, DONE.
REQ-022 SHALL accept a request only in IDLE with miss_req=1; on acceptance it SHALL register miss_addr, evict_dirty, evict_addr and evict_data.
REQ-023 SHALL force the low log2(LINE_BYTES) bits of every issued offchip_mem_addr to zero.
REQ-024 SHALL transition IDLE->WB when the captured evict_dirty=1, and IDLE->RD otherwise.
REQ-025 In WB, SHALL drive offchip_mem_write_en=1, offchip_mem_addr=aligned evict_addr and offchip_mem_wdata=captured data, held stable until offchip_mem_ready=1 is sampled; then WB->GAP.
REQ-026 GAP SHALL last exactly one cycle with both enables 0, then go to RD, so that the responder observes the request end.
REQ-027 In RD, SHALL drive offchip_mem_read_en=1 and offchip_mem_addr=aligned miss_addr; when offchip_mem_ready=1 is sampled it SHALL register offchip_mem_data into refill_data and go to DONE.
REQ-028 In DONE, SHALL assert refill_valid for exactly one cycle, then go to IDLE; refill_data SHALL hold until the next refill.
REQ-029 SHALL never assert offchip_mem_write_en and offchip_mem_read_en in the same cycle.
REQ-030 SHALL clear a phase cycle counter on entry to WB or RD and increment it each cycle the phase waits.
REQ-031 When the counter reaches TIMEOUT without ready, SHALL deassert the enable, pulse refill_err for one cycle and return to IDLE without refill_valid.
REQ-032 SHALL ignore offchip_mem_ready in IDLE, GAP and DONE.
REQ-033 SHALL ignore changes on miss_req and its operands while busy=1; a held miss_req in DONE SHALL start a new transaction only after returning to IDLE, giving a minimum of one idle cycle between transactions.
REQ-034 Ready latency is unbounded up to TIMEOUT; ready sampled on the first cycle of a phase SHALL be honoured, giving a 1-cycle phase minimum.

Reset
REQ-035 On rst=0, SHALL asynchronously set state IDLE, busy=0, both enables 0, refill_valid=0, refill_err=0, refill_data=0, offchip_mem_addr=0, offchip_mem_wdata=0 and the counter to 0.
REQ-036 Reset asserted mid-transaction SHALL abort it with no refill_valid or refill_err pulse after release.
REQ-037 After rst deasserts, SHALL accept a request on the first rising edge at which miss_req=1.

Verification
REQ-038 Clean miss: miss_req with miss_addr=0x1000_0014, evict_dirty=0, ready returned 3 cycles later -> read_en=1 with addr 0x1000_0000; refill_valid pulses once with data equal to the memory line; no write_en.
REQ-039 Dirty miss: evict_addr=0x2000_0040, evict_data=pattern A, miss_addr=0x3000_0000 -> write_en with addr 0x2000_0040 and wdata=A until ready; exactly one GAP cycle with both enables 0; then read at 0x3000_0000; refill_valid pulses once.
REQ-040 Timeout: TIMEOUT=8, ready never asserted -> read_en deasserts after 8 waiting cycles; refill_err pulses once; busy=0 the next cycle; no refill_valid.
REQ-041 Back-to-back: miss_req held high across two transactions -> at least one IDLE cycle between them; second addr captured at the second acceptance.
REQ-042 Reset mid-WB: rst=0 while write_en=1 -> write_en drops asynchronously; after release busy=0 and no pulses occur.
REQ-043 Protocol checks on all tests: read_en and write_en never high together; addr and wdata stable while an enable is held.
